// File: rtl/ras_commit.sv
// Commit-side return-address stack: tracks retired calls/returns in compressed
// {pc, repeat counter} form and streams committed entries to the fetch stack on flush.
module ras_commit #(
    parameter int LEN          = 64,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [32*COMMIT_WIDTH-1:0]  commit_pc,
    input  logic [COMMIT_WIDTH-1:0]     commit_call,
    input  logic [COMMIT_WIDTH-1:0]     commit_ret,
    input  logic                        flush,
    input  logic                        restore_ready,
    output logic                        restore_valid,
    output logic [$clog2(LEN)-1:0]      restore_addr,
    output logic [31:0]                 restore_pc,
    output logic [7:0]                  restore_counter,
    output logic                        restore_done,
    output logic [$clog2(LEN)-1:0]      restore_top,
    output logic                        busy
);
    localparam int AW = $clog2(LEN);
    localparam int DW = AW + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  top, top_m1, idx, idx_nxt, rd_addr;
    logic [DW-1:0]  depth, n_snap, n_nxt;
    logic [39:0]    mem [LEN];

    logic           ev_valid, ev_call, commit_en, hit;
    logic [31:0]    ev_pc, top_pc, rd_pc;
    logic [7:0]     top_cnt, rd_cnt;

    always_comb begin
        ev_valid = 1'b0;
        ev_call  = 1'b0;
        ev_pc    = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (!ev_valid && (commit_call[i] || commit_ret[i])) begin
                ev_valid = 1'b1;
                ev_call  = commit_call[i];
                ev_pc    = commit_pc[32*i +: 32];
            end
        end
    end

    assign top_m1            = top - AW'(1);
    assign {top_pc, top_cnt} = mem[top_m1];
    assign commit_en         = ev_valid && (state == IDLE);
    assign hit               = (depth != '0) && (top_pc == ev_pc) && (top_cnt != 8'hFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top   <= '0;
            depth <= '0;
        end else if (commit_en) begin
            if (ev_call) begin
                if (!hit) begin
                    top <= top + AW'(1);
                    if (depth != DW'(LEN))
                        depth <= depth + DW'(1);
                end
            end else if ((depth != '0) && (top_cnt == 8'h00)) begin
                top   <= top_m1;
                depth <= depth - DW'(1);
            end
        end
    end

    // Entry storage carries no reset; a full ring silently overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (commit_en) begin
            if (ev_call) begin
                if (hit)
                    mem[top_m1] <= {top_pc, top_cnt + 8'd1};
                else
                    mem[top] <= {ev_pc, 8'h00};
            end else if ((depth != '0) && (top_cnt != 8'h00)) begin
                mem[top_m1] <= {top_pc, top_cnt - 8'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= '0;
            n_snap <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            n_snap <= n_nxt;
        end
    end

    // A flush in any state restarts the pass from the oldest entry with a fresh snapshot.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        n_nxt     = n_snap;
        if (flush) begin
            idx_nxt   = '0;
            n_nxt     = depth;
            state_nxt = (depth == '0) ? DONE : STREAM;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                STREAM: begin
                    if (restore_ready) begin
                        if ({1'b0, idx} == n_snap - DW'(1))
                            state_nxt = DONE;
                        else
                            idx_nxt = idx + AW'(1);
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rd_addr         = top - n_snap[AW-1:0] + idx;
    assign {rd_pc, rd_cnt} = mem[rd_addr];

    assign restore_valid   = (state == STREAM);
    assign restore_addr    = restore_valid ? rd_addr : '0;
    assign restore_pc      = restore_valid ? rd_pc : '0;
    assign restore_counter = restore_valid ? rd_cnt : '0;
    assign restore_done    = (state == DONE);
    assign restore_top     = restore_done ? top : '0;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            assert ($countones(commit_call | commit_ret) <= 1);
            assert (!(busy && ev_valid));
        end
    end
endmodule

// File: doc/ras_commit.md
# ras_commit

Commit-side architectural return-address stack for the fetch branch predictor. It tracks calls and returns as they retire, using the same compressed entry format as the fetch-side speculative stack: PC plus an 8-bit repeat counter. On a pipeline flush it streams its committed contents back to the fetch-side stack, so the fetch side restarts from a correct, non-speculative state. It sits beside the commit stage and drives the restore port of the fetch return-address stack.

## Interface
- `LEN`, 64: stack entries, power of two.
- `COMMIT_WIDTH`, 2: retire slots per cycle.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `commit_pc` in 32×COMMIT_WIDTH: PC of each retiring instruction.
- `commit_call` in COMMIT_WIDTH: slot retires a call.
- `commit_ret` in COMMIT_WIDTH: slot retires a return.
- `flush` in 1: pipeline flush; start a restore.
- `restore_ready` in 1: fetch stack accepts a restore beat.
- `restore_valid` out 1: restore beat valid.
- `restore_addr` out $clog2(LEN): physical entry index.
- `restore_pc` out 32: entry PC.
- `restore_counter` out 8: entry repeat counter.
- `restore_done` out 1: one-cycle pulse marking the end of a restore.
- `restore_top` out $clog2(LEN): next-free pointer; valid with `restore_done`.
- `busy` out 1: restore in progress; fetch must hold.

## Operation
- Storage:
  - LEN-entry array of {pc[31:0], counter[7:0]}.
  - Pointer `top`: next free slot, wraps mod LEN.
  - `depth`: 0..LEN, width $clog2(LEN)+1.
- Event select: scan slots in ascending index; the first slot with `commit_call` or `commit_ret` is the only event this cycle. The backend guarantees at most one such slot; extra events are ignored (simulation assertion).
- Call (pc P) when `depth>0`, top entry PC == P and counter < 255: increment that entry's counter. `top` and `depth` are unchanged.
- Call, any other case:
  - Write {P, 0} at `top`; `top+1`.
  - `depth` increments, saturating at LEN.
  - When full, the oldest entry is overwritten (ring wrap).
- Return when `depth==0`: no-op.
- Return when top counter > 0: decrement the counter.
- Return when top counter == 0: `top-1`, `depth-1`.
- Commit events while `busy` are dropped (assertion); the backend never retires during a restore.
- FSM:
  - IDLE: on `flush` → STREAM, with idx=0 and snapshot n=`depth`. If n==0, go to DONE instead.
  - STREAM:
    - `restore_valid=1`.
    - `restore_addr = top - n + idx` (mod LEN), with the pc and counter of that entry.
    - On `restore_valid && restore_ready`: idx+1. After the last beat (idx==n-1) → DONE.
  - DONE: `restore_done=1`, `restore_top=top`, next → IDLE.
- `flush` in STREAM or DONE restarts from IDLE's entry action: idx=0, new snapshot. No `restore_done` is issued for the aborted pass.
- `busy` = state != IDLE.
- Beat order is oldest to newest. The fetch side writes each beat verbatim, then loads `restore_top`.

## Timing
- Reset (async assert, sync release):
  - `top=0`, `depth=0`, state IDLE.
  - All outputs 0: `restore_valid`, `restore_done`, `busy`, `restore_addr`, `restore_pc`, `restore_counter`, `restore_top`.
  - Array contents are don't-care.
- Commit update is visible in the state on the next edge. A call at cycle N followed by a flush at N+1 includes that call.
- A flush asserted at edge N:
  - `busy` and first `restore_valid` at N+1.
  - With `restore_ready` held high, n beats occupy cycles N+1..N+n.
  - `restore_done` at N+n+1, `busy` low at N+n+2.
  - Empty stack: `restore_done` at N+1.
- Beat fields are held stable while `restore_valid && !restore_ready`.
- Reset mid-restore: immediate return to IDLE with outputs 0. No done pulse.

## Test plan
- Reset, then calls with PCs 0x100, 0x200, 0x300, then flush with ready=1 → 3 beats: addr 0/1/2, pc 0x100/0x200/0x300, counter 0; done with `restore_top`=3; `busy` high for 4 cycles.
- Call 0x400 ×3 then one return, then flush → 1 beat {addr 0, pc 0x400, counter 1}, `restore_top`=1.
- Return on an empty stack, then flush → no beats; `restore_done` 1 cycle after flush, `restore_top`=0.
- LEN+2 calls with distinct PCs 0x1000+4i, then flush → LEN beats starting at addr 2 and wrapping. First pc is 0x1008, last is 0x1000+4(LEN+1); `restore_top`=2.
- 256 calls to 0x500 → entry {0x500, 255}; 257th call creates a second entry {0x500, 0}, `depth`=2.
- `restore_ready` toggled 1,0,0,1 during a 2-beat restore with a flush on the 3rd stream cycle → beat fields stable while stalled; stream restarts at idx 0; exactly one done pulse. Reset during STREAM → all outputs 0 on the next cycle.
